// File: rtl/qformat_pkg.sv
// Shared Qm.n format definitions for the arithmetic unit: default word geometry,
// divider state encoding and helpers for iteration count and saturation values.
package qformat_pkg;

    localparam int QF_Q = 8;
    localparam int QF_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } qdiv_state_e;

    // One quotient bit per cycle over the pre-shifted numerator.
    function automatic int qf_iter(input int n, input int q);
        return n + q;
    endfunction

    // Largest representable magnitude, optionally negated; callers keep the low n bits.
    function automatic logic [63:0] sat_value(input int n, input logic neg);
        logic [63:0] pos;
        pos = (64'd1 << (n - 1)) - 64'd1;
        return neg ? (~pos + 64'd1) : pos;
    endfunction

endpackage

// File: rtl/q_signmag.sv
// Conditional two's-complement negate. With negate tied to value's sign bit it
// yields the unsigned magnitude (-2^(W-1) maps to 2^(W-1)); otherwise it applies a sign.
module q_signmag #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/qdiv_seq.sv
// Sequential signed Qm.n divider, restoring shift-subtract, one quotient bit per clock.
// Define QDIV_ROUND_EN for round-half-away-from-zero; default build truncates toward zero.
module qdiv_seq
    import qformat_pkg::*;
#(
    parameter int Q = QF_Q,
    parameter int N = QF_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic         o_ovr,
    output logic         o_dvz
);

    localparam int ITER = qf_iter(N, Q);
    localparam int CW   = $clog2(ITER);
    localparam logic [N-1:0] SAT_POS = N'(sat_value(N, 1'b0));
    localparam logic [N-1:0] SAT_NEG = N'(sat_value(N, 1'b1));

    qdiv_state_e      state;
    logic             sign_q;
    logic [N-1:0]     dvs_q;
    logic [N+Q-1:0]   num_q;
    logic [N-1:0]     rem_q;
    logic [N+Q-2:0]   quo_q;
    logic [CW-1:0]    cnt_q;

    logic [N-1:0]     dvd_mag;
    logic [N-1:0]     dvs_mag;
    logic             start_sign;

    logic [N:0]       rem_shift;
    logic [N:0]       rem_diff;
    logic             rem_ge;
    logic [N-1:0]     rem_step;
    logic [N+Q-1:0]   quo_next;
    logic [N+Q:0]     raw_ext;
    logic             ovr_calc;
    logic [N-1:0]     mag_sel;
    logic [N-1:0]     neg_res;

    q_signmag #(.W(N)) u_dvd_mag (
        .value  (i_dividend),
        .negate (i_dividend[N-1]),
        .result (dvd_mag)
    );

    q_signmag #(.W(N)) u_dvs_mag (
        .value  (i_divisor),
        .negate (i_divisor[N-1]),
        .result (dvs_mag)
    );

    q_signmag #(.W(N)) u_quo_neg (
        .value  (mag_sel),
        .negate (sign_q),
        .result (neg_res)
    );

    assign start_sign = i_dividend[N-1] ^ i_divisor[N-1];

    always_comb begin
        // NOTE: combinational logic uses blocking '=' so each line sees the value computed above it.
        rem_shift = {rem_q, num_q[N+Q-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        // rem_q < dvs_q always holds, so the borrow bit alone decides the trial subtract.
        rem_ge    = ~rem_diff[N];
        rem_step  = rem_ge ? rem_diff[N-1:0] : rem_shift[N-1:0];
        quo_next  = {quo_q, rem_ge};
`ifdef QDIV_ROUND_EN
        raw_ext   = {1'b0, quo_next}
                  + {{(N+Q){1'b0}}, ({rem_step, 1'b0} >= {1'b0, dvs_q})};
`else
        raw_ext   = {1'b0, quo_next};
`endif
        ovr_calc  = |raw_ext[N+Q:N-1];
        mag_sel   = {1'b0, raw_ext[N-2:0]};
    end

    always_ff @(posedge i_clk) begin
        // NOTE: datapath registers are left out of reset; they are always loaded before use.
        if (i_rst) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_quotient <= '0;
            o_ovr      <= 1'b0;
            o_dvz      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        sign_q <= start_sign;
                        dvs_q  <= dvs_mag;
                        num_q  <= {dvd_mag, {Q{1'b0}}};
                        o_busy <= 1'b1;
                        o_ovr  <= 1'b0;
                        o_dvz  <= 1'b0;
                        if (dvs_mag == '0) begin
                            state      <= DONE;
                            o_done     <= 1'b1;
                            o_dvz      <= 1'b1;
                            o_ovr      <= 1'b1;
                            o_quotient <= start_sign ? SAT_NEG : SAT_POS;
                        end else begin
                            rem_q <= '0;
                            quo_q <= '0;
                            cnt_q <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    num_q <= {num_q[N+Q-2:0], 1'b0};
                    rem_q <= rem_step;
                    quo_q <= quo_next[N+Q-2:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        state      <= DONE;
                        o_done     <= 1'b1;
                        o_quotient <= neg_res;
                        o_ovr      <= ovr_calc;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
- Sequential signed fixed-point divider for the Qm.n datapath; it is the inverse operation of the combinational Q multiplier.
- Computes o_quotient = i_dividend / i_divisor in the same N-bit, Q-fractional-bit two's-complement format.
- Uses restoring shift-subtract, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit and is driven by a start/done handshake from the datapath controller.

Parameters:
- Q, 8, number of fractional bits.
- N, 16, total word width including the sign bit.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_start  input  1  request a division; sampled only in IDLE.
- i_dividend  input  N  two's-complement dividend, Q fractional bits.
- i_divisor  input  N  two's-complement divisor, Q fractional bits.
- o_busy  output  1  high in CALC and DONE.
- o_done  output  1  one-cycle pulse; result valid from this cycle.
- o_quotient  output  N  signed quotient, held until the next accepted start.
- o_ovr  output  1  quotient magnitude exceeds N-1 bits.
- o_dvz  output  1  divide by zero.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_quotient=0, o_ovr=0, o_dvz=0, state=IDLE.
- i_rst has priority over every other event, including mid-CALC. The operation is aborted and the state returns to IDLE on the next edge.
- IDLE, on i_start=1:
  - Latch sign = dividend[N-1] XOR divisor[N-1].
  - Latch magnitudes as N-bit unsigned values. -2^(N-1) maps to 2^(N-1).
  - Form the numerator as magnitude(dividend) << Q, N+Q bits wide.
  - Clear o_ovr and o_dvz.
  - If the divisor is 0, go to DONE. Otherwise clear the remainder and bit counter and go to CALC.
- CALC:
  - Runs exactly N+Q cycles.
  - Each cycle: remainder = {remainder, next numerator MSB}. If remainder >= magnitude(divisor), subtract it and shift in quotient bit 1; otherwise shift in 0.
  - When the counter reaches N+Q-1, go to DONE.
- Leaving CALC (registered):
  - o_ovr = OR of raw quotient bits [N+Q-1:N-1].
  - mag = {0, raw[N-2:0]}.
  - o_quotient = sign ? -mag : mag, truncated toward zero. A zero magnitude with a negative sign yields 0.
- Divide by zero (registered on the transition to DONE):
  - o_dvz=1, o_ovr=1.
  - o_quotient = sign ? -(2^(N-1)-1) : 2^(N-1)-1. The sign is the latched XOR.
- DONE: o_done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Normal operation: o_done is high in the (N+Q+1)th cycle after the start-accepting edge (25 cycles for the defaults).
  - Divide by zero: o_done is high 1 cycle after that edge.
- i_start while o_busy=1 is ignored; it is neither queued nor allowed to corrupt the operation.
- Inputs are sampled only at start acceptance, so they may change during CALC.
- A start in the same cycle that o_done is high is ignored. The earliest next accept is the following cycle, in IDLE.

Optional Feature:
- Macro: QDIV_ROUND_EN.
- When defined:
  - At the end of CALC, if 2*remainder >= magnitude(divisor), the raw quotient is incremented before the overflow check and sign application. The result is round-half-away-from-zero.
  - The increment can push the result into overflow, in which case o_ovr=1.
- When undefined: truncation toward zero, with no extra logic. Latency is identical either way.

Decomposition:
- Package qformat_pkg holds:
  - Default Q and N constants.
  - State encoding IDLE/CALC/DONE.
  - Localparam for iteration count N+Q.
  - Positive and negative saturation constants.
- One natural sub-module: q_signmag, a combinational magnitude/sign split plus conditional negate. It is instantiated twice for the input magnitudes and once for the output negate, and is reusable by the multiplier.

Test Plan:
- 0x0300 / 0x0200 (3.0/2.0): o_quotient=0x0180, ovr=0, dvz=0; o_done exactly 25 cycles after the start edge, busy high throughout.
- 0xFD00 / 0x0200 (-3.0/2.0): 0xFE80 (-1.5). 0x8000 / 0x0100 (-128/1.0): 0x8000 magnitude truncates to 0x0000 with ovr=1.
- 0x0200 / 0x0300 (2/3): 0x00AA without QDIV_ROUND_EN, 0x00AB with it. 0xFE00 / 0x0300: 0xFF56 or 0xFF55 respectively.
- 0x6400 / 0x0080 (100/0.5): ovr=1.
- 0x0100 / 0x0000: dvz=1, ovr=1, quotient=0x7FFF, done 1 cycle after start. 0xFF00 / 0x0000: 0x8001.
- Start accepted, then i_start pulsed at cycle 5 with different operands: ignored, the original result is returned.
- Separately, i_rst at cycle 10 of CALC: outputs return to their reset values the next cycle and no o_done appears.
